// File: rtl/nco_tdm_mc_core.sv
// Time-division multi-channel NCO: one shared phase/LUT pipeline serving NCH channels round-robin.
// Optional phase dither enabled by defining NCO_TDM_DITHER_EN; the quarter-wave table is built at elaboration.
module nco_tdm_mc_core #(
  parameter int NCH      = 4,
  parameter int APR      = 32,
  parameter int MPR      = 12,
  parameter int RAW      = 8,
  parameter     LUT_FILE = "nco_tdm_qw.hex"
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   clken,
  input  logic                   cfg_valid,
  output logic                   cfg_ready,
  input  logic [$clog2(NCH)-1:0] cfg_ch,
  input  logic [APR-1:0]         cfg_inc,
  input  logic [APR-1:0]         cfg_ofs,
  input  logic                   cfg_commit,
  input  logic                   sync_i,
  output logic signed [MPR-1:0]  fsin_o,
  output logic signed [MPR-1:0]  fcos_o,
  output logic [$clog2(NCH)-1:0] out_ch,
  output logic                   out_sof,
  output logic                   out_valid
);

  localparam int CW   = $clog2(NCH);
  localparam int TW   = MPR - 1;
  localparam int LOWW = APR - 2 - RAW;
  localparam int unused_lut_file_bits = $bits(LUT_FILE);

  // T[k] = round((2^TW-1)*sin((2k+1)*pi/2^(RAW+2))) via a Q30 Taylor series
  function automatic logic [TW-1:0] lut_val(input int k);
    longint x, x2, term, s, amp, v;
    x    = (longint'(64'd3373259426) * longint'(2 * k + 1)) >>> (RAW + 2);
    x2   = (x * x) >>> 30;
    term = x;
    s    = x;
    for (int n = 1; n < 10; n++) begin
      term = -((term * x2) >>> 30) / longint'((2 * n) * (2 * n + 1));
      s    = s + term;
    end
    amp = (longint'(1) <<< TW) - 1;
    v   = (amp * s + (longint'(1) <<< 29)) >>> 30;
    return v[TW-1:0];
  endfunction

  logic [TW-1:0] lut [2**RAW];
  for (genvar k = 0; k < 2**RAW; k++) begin : g_lut
    localparam logic [TW-1:0] TV = lut_val(k);
    assign lut[k] = TV;
  end

  logic [CW-1:0]  ch_cnt;
  logic [APR-1:0] acc [NCH];
  logic [APR-1:0] inc [NCH];
  logic [APR-1:0] ofs [NCH];
  logic [APR-1:0] sh_inc [NCH];
  logic [APR-1:0] sh_ofs [NCH];
  logic           commit_pending, sync_pending;
  logic           frame_end, cfg_we;

  assign frame_end = clken && (ch_cnt == CW'(NCH - 1));
  assign cfg_ready = !commit_pending;
  assign cfg_we    = clken && cfg_valid && cfg_ready;

  // Sync zeroing takes priority over the slot's own accumulator update at the boundary
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ch_cnt         <= '0;
      commit_pending <= 1'b0;
      sync_pending   <= 1'b0;
      for (int i = 0; i < NCH; i++) begin
        acc[i]    <= '0;
        inc[i]    <= '0;
        ofs[i]    <= '0;
        sh_inc[i] <= '0;
        sh_ofs[i] <= '0;
      end
    end else if (clken) begin
      ch_cnt <= frame_end ? '0 : ch_cnt + 1'b1;
      for (int i = 0; i < NCH; i++) begin
        if (cfg_we && cfg_ch == CW'(i)) begin
          sh_inc[i] <= cfg_inc;
          sh_ofs[i] <= cfg_ofs;
        end
        if (frame_end && sync_pending)
          acc[i] <= '0;
        else if (ch_cnt == CW'(i))
          acc[i] <= acc[i] + inc[i];
        if (frame_end && commit_pending) begin
          inc[i] <= sh_inc[i];
          ofs[i] <= sh_ofs[i];
        end
      end
      commit_pending <= cfg_commit | (commit_pending & ~frame_end);
      sync_pending   <= sync_i | (sync_pending & ~frame_end);
    end
  end

  logic [APR-1:0] acc_sel, ofs_sel, phase0;

  always_comb begin
    acc_sel = '0;
    ofs_sel = '0;
    for (int i = 0; i < NCH; i++) begin
      if (ch_cnt == CW'(i)) begin
        acc_sel = acc[i];
        ofs_sel = ofs[i];
      end
    end
  end

  assign phase0 = acc_sel + ofs_sel;

  logic [APR-1:0] p1, ph_s1;
  logic [1:0]     q2, q3;
  logic [RAW-1:0] a2;
  logic [TW-1:0]  t_a, t_na;
  logic [CW-1:0]  ch1, ch2, ch3;
  logic           v1, v2, v3;
  logic           unused_low;

`ifdef NCO_TDM_DITHER_EN
  logic [15:0]    lfsr;
  logic [APR-1:0] dith;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      lfsr <= 16'hACE1;
    else if (clken)
      lfsr <= {lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5], lfsr[15:1]};
  end

  // Dither is aligned to the top of the bits discarded below the LUT address
  if (LOWW >= 16) begin : g_dith_wide
    assign dith = APR'(lfsr) << (LOWW - 16);
  end else begin : g_dith_narrow
    assign dith = APR'(lfsr >> (16 - LOWW));
  end

  assign ph_s1 = p1 + dith;
`else
  assign ph_s1 = p1;
`endif

  assign unused_low = ^ph_s1[LOWW-1:0];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      p1   <= '0;
      q2   <= '0;
      a2   <= '0;
      q3   <= '0;
      t_a  <= '0;
      t_na <= '0;
      ch1  <= '0;
      ch2  <= '0;
      ch3  <= '0;
      v1   <= 1'b0;
      v2   <= 1'b0;
      v3   <= 1'b0;
    end else if (clken) begin
      p1   <= phase0;
      ch1  <= ch_cnt;
      v1   <= 1'b1;
      q2   <= ph_s1[APR-1 -: 2];
      a2   <= ph_s1[APR-3 -: RAW];
      ch2  <= ch1;
      v2   <= v1;
      t_a  <= lut[a2];
      t_na <= lut[~a2];
      q3   <= q2;
      ch3  <= ch2;
      v3   <= v2;
    end
  end

  logic signed [MPR-1:0] pos_a, pos_na, sin_n, cos_n;

  assign pos_a  = $signed({1'b0, t_a});
  assign pos_na = $signed({1'b0, t_na});

  // Quadrant folding of the quarter-wave samples into full sin/cos
  always_comb begin
    sin_n = pos_a;
    cos_n = pos_na;
    case (q3)
      2'd0: begin sin_n = pos_a;   cos_n = pos_na;  end
      2'd1: begin sin_n = pos_na;  cos_n = -pos_a;  end
      2'd2: begin sin_n = -pos_a;  cos_n = -pos_na; end
      2'd3: begin sin_n = -pos_na; cos_n = pos_a;   end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fsin_o    <= '0;
      fcos_o    <= '0;
      out_ch    <= '0;
      out_sof   <= 1'b0;
      out_valid <= 1'b0;
    end else if (clken) begin
      fsin_o    <= sin_n;
      fcos_o    <= cos_n;
      out_ch    <= ch3;
      out_sof   <= v3 && (ch3 == '0);
      out_valid <= v3;
    end
  end

endmodule

// File: tb/tb_nco_tdm_mc_core.sv
// Directed self-checking bench for nco_tdm_mc_core (NCH=4, APR=32, MPR=12, RAW=8, dither off).
module tb_nco_tdm_mc_core;

  localparam int BIG = 1 << 30;

  logic               clk = 1'b0;
  logic               reset, clken, cfg_valid, cfg_commit, sync_i;
  logic               cfg_ready;
  logic [1:0]         cfg_ch;
  logic [31:0]        cfg_inc, cfg_ofs;
  logic signed [11:0] fsin_o, fcos_o;
  logic [1:0]         out_ch;
  logic               out_sof, out_valid;

  int vectors     = 0;
  int miscompares = 0;
  int n_en        = 0;
  int w1          = BIG;
  int fc          = BIG;
  int sync_f      = BIG;
  int sin_q [4]   = '{6, 2047, -6, -2047};
  int cos_q [4]   = '{2047, -6, -2047, 6};

  nco_tdm_mc_core #(.NCH(4), .APR(32), .MPR(12), .RAW(8)) dut (
    .clk(clk), .reset(reset), .clken(clken),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_ch(cfg_ch),
    .cfg_inc(cfg_inc), .cfg_ofs(cfg_ofs), .cfg_commit(cfg_commit),
    .sync_i(sync_i), .fsin_o(fsin_o), .fcos_o(fcos_o),
    .out_ch(out_ch), .out_sof(out_sof), .out_valid(out_valid)
  );

  always #5 clk = ~clk;

  // Quadrant expected for channel c issued in frame f, from the scenario events so far
  function automatic int exp_quad(int f, int c);
    int q = 0;
    if (c == 1) begin
      if (f > sync_f) q = (f - sync_f - 1) % 4;
      else if (f > w1) q = (f - w1 - 1) % 4;
    end
    if (c == 2 && f > fc) q = 2;
    return q;
  endfunction

  task automatic idle();
    cfg_valid = 1'b0; cfg_commit = 1'b0; sync_i = 1'b0;
    cfg_ch = 2'd0; cfg_inc = '0; cfg_ofs = '0;
  endtask

  task automatic step();
    @(posedge clk);
    if (clken && !reset) n_en++;
    @(negedge clk);
  endtask

  task automatic to_slot0();
    clken = 1'b1;
    while (n_en % 4 != 0) step();
  endtask

  task automatic test_reset();
    reset = 1'b1; clken = 1'b1; idle();
    step(); step();
    vectors += 6;
    if (fsin_o !== 12'sd0)  begin miscompares++; $display("[TB] FAIL reset_fsin got %0d want 0", fsin_o); end
    if (fcos_o !== 12'sd0)  begin miscompares++; $display("[TB] FAIL reset_fcos got %0d want 0", fcos_o); end
    if (out_ch !== 2'd0)    begin miscompares++; $display("[TB] FAIL reset_out_ch got %0d want 0", out_ch); end
    if (out_sof !== 1'b0)   begin miscompares++; $display("[TB] FAIL reset_out_sof got %0b want 0", out_sof); end
    if (out_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_out_valid got %0b want 0", out_valid); end
    if (cfg_ready !== 1'b1) begin miscompares++; $display("[TB] FAIL reset_cfg_ready got %0b want 1", cfg_ready); end
    reset = 1'b0; n_en = 0;
    for (int k = 1; k <= 3; k++) begin
      step();
      vectors++;
      if (out_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL startup_valid cycle %0d got %0b want 0", k, out_valid); end
    end
    for (int k = 4; k <= 15; k++) begin
      int c;
      step();
      c = (n_en - 4) % 4;
      vectors += 5;
      if (out_valid !== 1'b1)        begin miscompares++; $display("[TB] FAIL startup_valid cycle %0d got %0b want 1", k, out_valid); end
      if (out_ch !== 2'(c))          begin miscompares++; $display("[TB] FAIL startup_ch cycle %0d got %0d want %0d", k, out_ch, c); end
      if (out_sof !== (c == 0))      begin miscompares++; $display("[TB] FAIL startup_sof cycle %0d got %0b want %0b", k, out_sof, c == 0); end
      if (int'(fsin_o) !== 6)        begin miscompares++; $display("[TB] FAIL startup_sin cycle %0d got %0d want 6", k, fsin_o); end
      if (int'(fcos_o) !== 2047)     begin miscompares++; $display("[TB] FAIL startup_cos cycle %0d got %0d want 2047", k, fcos_o); end
    end
  endtask

  task automatic test_inc_commit();
    to_slot0();
    w1 = n_en / 4;
    cfg_valid = 1'b1; cfg_ch = 2'd1; cfg_inc = 32'h4000_0000; cfg_ofs = '0; cfg_commit = 1'b1;
    step(); idle();
    for (int k = 0; k < 28; k++) begin
      int f, c, q;
      step();
      f = (n_en - 4) / 4; c = (n_en - 4) % 4; q = exp_quad(f, c);
      vectors += 3;
      if (out_ch !== 2'(c))          begin miscompares++; $display("[TB] FAIL inc_ch f%0d got %0d want %0d", f, out_ch, c); end
      if (int'(fsin_o) !== sin_q[q]) begin miscompares++; $display("[TB] FAIL inc_sin f%0d ch%0d got %0d want %0d", f, c, fsin_o, sin_q[q]); end
      if (int'(fcos_o) !== cos_q[q]) begin miscompares++; $display("[TB] FAIL inc_cos f%0d ch%0d got %0d want %0d", f, c, fcos_o, cos_q[q]); end
    end
  endtask

  task automatic test_ofs_commit();
    to_slot0();
    cfg_valid = 1'b1; cfg_ch = 2'd2; cfg_ofs = 32'h8000_0000;
    step(); idle();
    for (int k = 0; k < 8; k++) begin
      int f, c, q;
      step();
      f = (n_en - 4) / 4; c = (n_en - 4) % 4; q = exp_quad(f, c);
      vectors += 2;
      if (int'(fsin_o) !== sin_q[q]) begin miscompares++; $display("[TB] FAIL ofs_nocommit_sin f%0d ch%0d got %0d want %0d", f, c, fsin_o, sin_q[q]); end
      if (int'(fcos_o) !== cos_q[q]) begin miscompares++; $display("[TB] FAIL ofs_nocommit_cos f%0d ch%0d got %0d want %0d", f, c, fcos_o, cos_q[q]); end
    end
    to_slot0();
    fc = n_en / 4;
    cfg_commit = 1'b1;
    step(); idle();
    for (int k = 0; k < 16; k++) begin
      int f, c, q;
      step();
      f = (n_en - 4) / 4; c = (n_en - 4) % 4; q = exp_quad(f, c);
      vectors += 2;
      if (int'(fsin_o) !== sin_q[q]) begin miscompares++; $display("[TB] FAIL ofs_commit_sin f%0d ch%0d got %0d want %0d", f, c, fsin_o, sin_q[q]); end
      if (int'(fcos_o) !== cos_q[q]) begin miscompares++; $display("[TB] FAIL ofs_commit_cos f%0d ch%0d got %0d want %0d", f, c, fcos_o, cos_q[q]); end
    end
  endtask

  task automatic test_commit_ready();
    to_slot0();
    cfg_commit = 1'b1;
    step(); idle();
    vectors++;
    if (cfg_ready !== 1'b0) begin miscompares++; $display("[TB] FAIL ready_after_commit got %0b want 0", cfg_ready); end
    cfg_valid = 1'b1; cfg_ch = 2'd3; cfg_inc = 32'h4000_0000; cfg_ofs = 32'h4000_0000;
    step(); idle();
    vectors++;
    if (cfg_ready !== 1'b0) begin miscompares++; $display("[TB] FAIL ready_pending_slot1 got %0b want 0", cfg_ready); end
    step();
    vectors++;
    if (cfg_ready !== 1'b0) begin miscompares++; $display("[TB] FAIL ready_pending_slot2 got %0b want 0", cfg_ready); end
    step();
    vectors++;
    if (cfg_ready !== 1'b1) begin miscompares++; $display("[TB] FAIL ready_after_boundary got %0b want 1", cfg_ready); end
    cfg_commit = 1'b1;
    step(); idle();
    for (int k = 0; k < 16; k++) begin
      int f, c, q;
      step();
      f = (n_en - 4) / 4; c = (n_en - 4) % 4; q = exp_quad(f, c);
      vectors += 2;
      if (int'(fsin_o) !== sin_q[q]) begin miscompares++; $display("[TB] FAIL dropped_write_sin f%0d ch%0d got %0d want %0d", f, c, fsin_o, sin_q[q]); end
      if (int'(fcos_o) !== cos_q[q]) begin miscompares++; $display("[TB] FAIL dropped_write_cos f%0d ch%0d got %0d want %0d", f, c, fcos_o, cos_q[q]); end
    end
  endtask

  task automatic test_sync();
    to_slot0();
    step();
    sync_f = n_en / 4;
    sync_i = 1'b1;
    step(); idle();
    for (int k = 0; k < 24; k++) begin
      int f, c, q;
      step();
      f = (n_en - 4) / 4; c = (n_en - 4) % 4; q = exp_quad(f, c);
      vectors += 2;
      if (int'(fsin_o) !== sin_q[q]) begin miscompares++; $display("[TB] FAIL sync_sin f%0d ch%0d got %0d want %0d", f, c, fsin_o, sin_q[q]); end
      if (int'(fcos_o) !== cos_q[q]) begin miscompares++; $display("[TB] FAIL sync_cos f%0d ch%0d got %0d want %0d", f, c, fcos_o, cos_q[q]); end
    end
  endtask

  task automatic test_clken();
    to_slot0();
    for (int i = 0; i < 24; i++) begin
      int f, c, q;
      clken = (i % 2 == 0);
      idle();
      if (!clken) begin
        cfg_valid = 1'b1; cfg_ch = 2'd0; cfg_ofs = 32'h4000_0000; cfg_commit = 1'b1; sync_i = 1'b1;
      end
      step();
      f = (n_en - 4) / 4; c = (n_en - 4) % 4; q = exp_quad(f, c);
      vectors += 4;
      if (cfg_ready !== 1'b1)        begin miscompares++; $display("[TB] FAIL clken_ready step%0d got %0b want 1", i, cfg_ready); end
      if (out_ch !== 2'(c))          begin miscompares++; $display("[TB] FAIL clken_ch step%0d got %0d want %0d", i, out_ch, c); end
      if (int'(fsin_o) !== sin_q[q]) begin miscompares++; $display("[TB] FAIL clken_sin step%0d got %0d want %0d", i, fsin_o, sin_q[q]); end
      if (int'(fcos_o) !== cos_q[q]) begin miscompares++; $display("[TB] FAIL clken_cos step%0d got %0d want %0d", i, fcos_o, cos_q[q]); end
    end
    idle();
    to_slot0();
    cfg_commit = 1'b1;
    step(); idle();
    for (int k = 0; k < 12; k++) begin
      int f, c, q;
      step();
      f = (n_en - 4) / 4; c = (n_en - 4) % 4; q = exp_quad(f, c);
      vectors += 2;
      if (int'(fsin_o) !== sin_q[q]) begin miscompares++; $display("[TB] FAIL clken_cfg_sin f%0d ch%0d got %0d want %0d", f, c, fsin_o, sin_q[q]); end
      if (int'(fcos_o) !== cos_q[q]) begin miscompares++; $display("[TB] FAIL clken_cfg_cos f%0d ch%0d got %0d want %0d", f, c, fcos_o, cos_q[q]); end
    end
  endtask

  task automatic test_reset_mid();
    to_slot0();
    cfg_commit = 1'b1;
    step(); idle();
    vectors++;
    if (cfg_ready !== 1'b0) begin miscompares++; $display("[TB] FAIL pre_reset_ready got %0b want 0", cfg_ready); end
    #2 reset = 1'b1;
    #1;
    vectors += 6;
    if (fsin_o !== 12'sd0)  begin miscompares++; $display("[TB] FAIL midreset_fsin got %0d want 0", fsin_o); end
    if (fcos_o !== 12'sd0)  begin miscompares++; $display("[TB] FAIL midreset_fcos got %0d want 0", fcos_o); end
    if (out_ch !== 2'd0)    begin miscompares++; $display("[TB] FAIL midreset_out_ch got %0d want 0", out_ch); end
    if (out_sof !== 1'b0)   begin miscompares++; $display("[TB] FAIL midreset_out_sof got %0b want 0", out_sof); end
    if (out_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL midreset_out_valid got %0b want 0", out_valid); end
    if (cfg_ready !== 1'b1) begin miscompares++; $display("[TB] FAIL midreset_cfg_ready got %0b want 1", cfg_ready); end
    @(negedge clk);
    reset = 1'b0; n_en = 0; w1 = BIG; fc = BIG; sync_f = BIG;
    for (int k = 1; k <= 3; k++) begin
      step();
      vectors++;
      if (out_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL rerun_valid cycle %0d got %0b want 0", k, out_valid); end
    end
    for (int k = 4; k <= 11; k++) begin
      int c;
      step();
      c = (n_en - 4) % 4;
      vectors += 3;
      if (out_valid !== 1'b1)    begin miscompares++; $display("[TB] FAIL rerun_valid cycle %0d got %0b want 1", k, out_valid); end
      if (int'(fsin_o) !== 6)    begin miscompares++; $display("[TB] FAIL rerun_sin ch%0d got %0d want 6", c, fsin_o); end
      if (int'(fcos_o) !== 2047) begin miscompares++; $display("[TB] FAIL rerun_cos ch%0d got %0d want 2047", c, fcos_o); end
    end
  endtask

  initial begin
    test_reset();
    test_inc_commit();
    test_ofs_commit();
    test_commit_ready();
    test_sync();
    test_clken();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired at %0t", $time);
    $fatal(1, "[TB] watchdog");
  end

endmodule
